mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Arbiter and sequencer for the single external memory port, shared by two requesters: the instruction-cache line-refill engine and the MEM-stage data access. It grants one transaction at a time and drives the downstream request handshake. It steers read beats or the write acknowledge back to the owner. It reports a busy flag to the pipeline controller so IF/MEM stalls can be raised.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data beat width
- LINE_BEATS, 4, beats per icache refill (power of two, 2..16)
- STARVE_LIMIT, 8, consecutive data grants tolerated while icache waits (guard build only)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- ic_req_i  in  1  refill request; held until ic_gnt_o
- ic_addr_i  in  ADDR_W  line-aligned refill address
- ic_gnt_o  out  1  refill accepted downstream (1-cycle pulse)
- ic_rvalid_o / ic_rdata_o / ic_last_o  out  1/DATA_W/1  refill beat, last beat marker
- dc_req_i  in  1  data request; held until dc_gnt_o
- dc_we_i / dc_addr_i / dc_wdata_i / dc_wmask_i  in  1/ADDR_W/DATA_W/DATA_W/8  data access fields
- dc_gnt_o  out  1  data access accepted downstream (1-cycle pulse)
- dc_rvalid_o / dc_rdata_o  out  1/DATA_W  read response
- dc_bvalid_o  out  1  write complete
- mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_wmask_o  out  1/1/ADDR_W/DATA_W/DATA_W/8  downstream request
- mem_len_o  out  4  beats minus one (LINE_BEATS-1 for refill, 0 for data)
- mem_ready_i  in  1  downstream accepts request this cycle
- mem_rvalid_i / mem_rdata_i  in  1/DATA_W  read beat
- mem_bvalid_i  in  1  write acknowledge
- arb_busy_o  out  1  state != IDLE

## Operation
- States: IDLE, IC_REQ, IC_DATA, DC_REQ, DC_DATA.
- IDLE: dc_req_i wins over ic_req_i when both are high (strict priority; see Configuration). The winner's fields are latched into internal registers and the FSM moves to X_REQ. With no request, the FSM stays in IDLE.
- X_REQ: mem_req_o=1 with latched fields. When mem_ready_i=1, x_gnt_o pulses in the same cycle and the FSM moves to X_DATA next.
- IC_DATA: each mem_rvalid_i is forwarded combinationally to ic_rvalid_o/ic_rdata_o. The beat counter increments per beat. ic_last_o is asserted on the beat where counter==LINE_BEATS-1, and the FSM moves to IDLE next. mem_rlast is not used; the count is authoritative.
- DC_DATA, read: the first mem_rvalid_i is forwarded as dc_rvalid_o, then the FSM moves to IDLE.
- DC_DATA, write: mem_bvalid_i is forwarded as dc_bvalid_o, then the FSM moves to IDLE.
- mem_rvalid_i/mem_bvalid_i outside X_DATA, or not matching the owner type, are ignored. Owner-side outputs stay 0.
- A requester dropping req before gnt is a protocol error. The latched transaction still completes.
- mem_req_o and all mem_* fields are 0 outside X_REQ.

## Timing
- Reset (rst low, any state, mid-burst included): state=IDLE, beat counter=0, starve counter=0, all outputs 0. Any response arriving after reset release is ignored.
- Request sampled at edge T in IDLE gives mem_req_o high from T+1.
- With mem_ready_i high at T+1, gnt pulses at T+1.
- The earliest returned beat is forwarded at T+2, with zero added latency.
- The terminal beat/ack at cycle C gives IDLE at C+1, and a new grant is possible from mem_req_o at C+2. This is a one-cycle bubble between back-to-back transactions.
- arb_busy_o is decoded from the state register (glitch-free, registered source).

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A starve counter increments on each dc grant taken while ic_req_i=1.
  - When the counter equals STARVE_LIMIT, the next IDLE arbitration grants icache even if dc_req_i=1.
  - The counter clears on any ic grant or whenever ic_req_i=0.
- ARB_STARVE_GUARD_EN undefined: strict data-over-instruction priority, and no counter is built.

## Structure
- defines.v holds:
  - ARB_STATE_IDLE/IC_REQ/IC_DATA/DC_REQ/DC_DATA as 3-bit codes
  - the `Arb_State_Bus width
  - the mem_len_o width constant
- Sub-module arb_beat_counter: clear/enable beat counter with terminal flag, parameterized by LINE_BEATS.
- The async-reset state register lives in mem_bus_arbiter itself.

## Test plan
- Lone refill at 0x8000_0040, mem_ready_i immediate, beats D0..D3 on consecutive cycles:
  - ic_gnt_o pulse 1 cycle after req.
  - 4 ic_rvalid_o with ic_last_o only on D3.
  - mem_len_o=3.
- ic_req_i and dc_req_i (read 0x1000) rise together:
  - dc granted first, dc_rvalid_o returns mem data.
  - Refill starts after the 1-cycle IDLE bubble.
- Data write 0x2000, wmask 0x0F, mem_ready_i held low 3 cycles:
  - mem_req_o held 3 cycles with stable fields.
  - dc_gnt_o on the 4th cycle.
  - dc_bvalid_o on mem_bvalid_i, then IDLE.
- rst driven low after beat 2 of a refill:
  - All outputs 0 immediately.
  - Stray mem_rvalid_i after release produces no ic_rvalid_o.
- ARB_STARVE_GUARD_EN with STARVE_LIMIT=8, dc_req_i and ic_req_i held high continuously:
  - 8 dc grants, then 1 ic grant, then dc resumes.
  - Without the macro, ic is never granted.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the external memory port arbiter.
// State codes, state-bus width and mem_len_o width.
package mem_bus_arbiter_pkg;

    localparam int ARB_STATE_W = 3;
    localparam int MEM_LEN_W   = 4;

    typedef enum logic [ARB_STATE_W-1:0] {
        ARB_STATE_IDLE    = 3'd0,
        ARB_STATE_IC_REQ  = 3'd1,
        ARB_STATE_IC_DATA = 3'd2,
        ARB_STATE_DC_REQ  = 3'd3,
        ARB_STATE_DC_DATA = 3'd4
    } arb_state_e;

    function automatic logic [MEM_LEN_W-1:0] beats_to_len(input int beats);
        return MEM_LEN_W'(beats - 1);
    endfunction

endpackage

// File: rtl/arb_beat_counter.sv
// Refill beat counter with clear/enable and terminal-beat flag.
// Wraps to zero when a beat is counted on the terminal value.
module arb_beat_counter #(
    parameter int LINE_BEATS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_term
);

    localparam int CNT_W = $clog2(LINE_BEATS);

    logic [CNT_W-1:0] r_cnt;

    assign o_term = (r_cnt == CNT_W'(LINE_BEATS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter/sequencer for the external memory port.
// Optional icache anti-starvation guard: ARB_STARVE_GUARD_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int LINE_BEATS   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ic_req_i,
    input  logic [ADDR_W-1:0]   ic_addr_i,
    output logic                ic_gnt_o,
    output logic                ic_rvalid_o,
    output logic [DATA_W-1:0]   ic_rdata_o,
    output logic                ic_last_o,
    input  logic                dc_req_i,
    input  logic                dc_we_i,
    input  logic [ADDR_W-1:0]   dc_addr_i,
    input  logic [DATA_W-1:0]   dc_wdata_i,
    input  logic [DATA_W/8-1:0] dc_wmask_i,
    output logic                dc_gnt_o,
    output logic                dc_rvalid_o,
    output logic [DATA_W-1:0]   dc_rdata_o,
    output logic                dc_bvalid_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    output logic [MEM_LEN_W-1:0] mem_len_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_bvalid_i,
    output logic                arb_busy_o
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e          r_state;
    arb_state_e          w_next;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [MASK_W-1:0]   r_wmask;
    logic                w_starve;
    logic                w_pick_ic;
    logic                w_pick_dc;
    logic                w_beat;
    logic                w_term;

    assign w_pick_ic  = ic_req_i & (~dc_req_i | w_starve);
    assign w_pick_dc  = dc_req_i & ~w_pick_ic;
    assign w_beat     = (r_state == ARB_STATE_IC_DATA) & mem_rvalid_i;
    assign arb_busy_o = (r_state != ARB_STATE_IDLE);

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] r_starve;

    assign w_starve = (r_starve == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (ic_gnt_o || !ic_req_i) begin
            r_starve <= '0;
        end else if (dc_gnt_o) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    logic w_unused_limit;

    assign w_unused_limit = ^STARVE_LIMIT;
    assign w_starve       = 1'b0;
`endif

    arb_beat_counter #(
        .LINE_BEATS (LINE_BEATS)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != ARB_STATE_IC_DATA),
        .i_en   (w_beat),
        .o_term (w_term)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_STATE_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Refill carries no write payload, so its latched fields are zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (r_state == ARB_STATE_IDLE) begin
            if (w_pick_dc) begin
                r_we    <= dc_we_i;
                r_addr  <= dc_addr_i;
                r_wdata <= dc_wdata_i;
                r_wmask <= dc_wmask_i;
            end else if (w_pick_ic) begin
                r_we    <= 1'b0;
                r_addr  <= ic_addr_i;
                r_wdata <= '0;
                r_wmask <= '0;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        ic_gnt_o    = 1'b0;
        ic_rvalid_o = 1'b0;
        ic_rdata_o  = '0;
        ic_last_o   = 1'b0;
        dc_gnt_o    = 1'b0;
        dc_rvalid_o = 1'b0;
        dc_rdata_o  = '0;
        dc_bvalid_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        mem_len_o   = '0;
        unique case (r_state)
            ARB_STATE_IDLE: begin
                if (w_pick_dc) begin
                    w_next = ARB_STATE_DC_REQ;
                end else if (w_pick_ic) begin
                    w_next = ARB_STATE_IC_REQ;
                end
            end
            ARB_STATE_IC_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = r_addr;
                mem_len_o  = beats_to_len(LINE_BEATS);
                ic_gnt_o   = mem_ready_i;
                if (mem_ready_i) begin
                    w_next = ARB_STATE_IC_DATA;
                end
            end
            ARB_STATE_DC_REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = r_we;
                mem_addr_o  = r_addr;
                mem_wdata_o = r_wdata;
                mem_wmask_o = r_wmask;
                dc_gnt_o    = mem_ready_i;
                if (mem_ready_i) begin
                    w_next = ARB_STATE_DC_DATA;
                end
            end
            ARB_STATE_IC_DATA: begin
                ic_rvalid_o = mem_rvalid_i;
                ic_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
                ic_last_o   = w_beat & w_term;
                if (w_beat && w_term) begin
                    w_next = ARB_STATE_IDLE;
                end
            end
            ARB_STATE_DC_DATA: begin
                if (r_we) begin
                    dc_bvalid_o = mem_bvalid_i;
                    if (mem_bvalid_i) begin
                        w_next = ARB_STATE_IDLE;
                    end
                end else begin
                    dc_rvalid_o = mem_rvalid_i;
                    dc_rdata_o  = mem_rvalid_i ? mem_rdata_i : '0;
                    if (mem_rvalid_i) begin
                        w_next = ARB_STATE_IDLE;
                    end
                end
            end
            default: begin
                w_next = ARB_STATE_IDLE;
            end
        endcase
    end

endmodule
